elixirchip_es1_spu_op_xor_acc: RTL
==================================

Name: elixirchip_es1_spu_op_xor_acc

Overview:
- Downstream accumulate stage for the SPU XOR op.
- Consumes the per-cycle operand stream and folds each valid word into a running rotate-XOR checksum.
- Also keeps a saturating count of accepted words.
- Uses the same cke / s_clear / s_valid pipeline conventions as the other es1 SPU ops, so it chains directly behind elixirchip_es1_spu_op_xor.

Parameters:
- LATENCY, 1: total cycles from input to m_data, counted in cke-high cycles; must be >= 1.
- DATA_BITS, 8: data width.
- data_t, logic [DATA_BITS-1:0]: data type.
- ROTATE, 0: left-rotate applied to the accumulator before each fold; legal range 0..DATA_BITS-1.
- CLEAR_DATA, '0: accumulator value after reset or clear.
- COUNT_BITS, 16: width of the accepted-word counter.
- DEVICE, "RTL": device name.
- SIMULATION, "false": simulation flag.
- DEBUG, "false": debug flag.

Ports:
- reset, input, 1: synchronous, active-high reset.
- clk, input, 1: clock.
- cke, input, 1: clock enable; all state advances only when cke=1.
- s_data, input, DATA_BITS: operand word.
- s_clear, input, 1: restart accumulation.
- s_valid, input, 1: fold s_data this cycle.
- m_data, output, DATA_BITS: accumulator value.
- m_count, output, COUNT_BITS: accepted-word count.
- m_valid, output, 1: s_valid delayed by LATENCY.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- On reset:
  - acc = CLEAR_DATA, cnt = 0.
  - All delay stages for data = CLEAR_DATA, for count = 0, for valid = 0.
  - Therefore m_data = CLEAR_DATA, m_count = 0, m_valid = 0.
- cke=0: every register holds, including the pipeline; inputs are ignored.
- cke=1: base = s_clear ? CLEAR_DATA : acc.
  - If s_valid: acc <= rotl(base, ROTATE) ^ s_data.
  - Else: acc <= base.
  - cnt <= (s_clear ? 0 : cnt) + s_valid, saturating at 2^COUNT_BITS-1 (hold at max, no wrap).
- Simultaneous s_clear and s_valid means clear-then-fold: the result is rotl(CLEAR_DATA, ROTATE) ^ s_data, with cnt = 1.
- s_clear alone: acc = CLEAR_DATA, cnt = 0.
- Pipeline timing:
  - acc, cnt and the valid flag form stage 1.
  - LATENCY-1 further cke-gated register stages follow; m_* are the last stage.
  - With LATENCY=1, m_* are acc/cnt/valid directly.
- Rotation is a pure rewire; ROTATE=0 gives a plain XOR fold. No arithmetic carry anywhere except the counter.
- Reset mid-stream: the next cycle shows reset values, and in-flight pipeline contents are discarded. The first post-reset input is visible LATENCY cke-cycles later.
- A parameter check rejects LATENCY<1 or ROTATE>=DATA_BITS (elaboration $error).

Decomposition:
- Package elixirchip_es1_spu_pkg: rotl function (data width, amount) and the saturating-increment function.
- One sub-module, elixirchip_es1_spu_delay:
  - Parameters DEPTH, data_t and INIT.
  - Ports reset/clk/cke/s_data/m_data.
  - DEPTH=0 is passthrough.
  - Instantiated three times (data, count, valid) with DEPTH=LATENCY-1.

Test Plan:
(All use DATA_BITS=8, CLEAR_DATA=8'h00, LATENCY=1, COUNT_BITS=16 unless stated.)
1. Reset held 3 cycles, then released with inputs idle -> m_data=8'h00, m_count=0, m_valid=0.
2. Clear; then valid 8'h0F, 8'hF0, 8'hFF on consecutive cke cycles -> m_data 0F, FF, 00; m_count 1, 2, 3; m_valid=1 each cycle.
3. After accumulating 8'h33, drive s_clear=1 with s_valid=1 and s_data=8'h5A -> m_data=5A, m_count=1. Then s_clear alone -> m_data=00, m_count=0.
4. LATENCY=3 with random cke (10% low): valid 8'hA5 after clear -> m_data=A5 appears exactly 3 cke-high cycles later. Contents hold while cke=0, and a valid word presented during cke=0 is not counted.
5. ROTATE=1: clear, then valid 8'h81, then valid 8'h00 -> m_data 81, then 03. Scoreboard against a reference model for 1000 random cycles.
6. COUNT_BITS=2: 5 consecutive valids -> m_count 1, 2, 3, 3, 3. Then reset asserted mid-stream -> m_count=0 and m_data=CLEAR_DATA on the next cycle.

Source files
------------

// File: rtl/elixirchip_es1_spu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_pkg
//  Brief    : Shared helpers for the es1 SPU ops (rotate and saturating count).
//  Revision : 1.0
// ============================================================================

package elixirchip_es1_spu_pkg;

    localparam int unsigned c_max_bits = 64;

    // Left-rotate of the low 'width' bits; callers pass constant width/amount so
    // this collapses to wiring.
    function automatic logic [63:0] rotl(
        input logic [63:0] data,
        input int unsigned width,
        input int unsigned amount
    );
        logic [63:0] mask;
        logic [63:0] d;
        mask = (width >= c_max_bits) ? '1 : ((64'd1 << width) - 64'd1);
        d    = data & mask;
        if (amount == 0) begin
            return d;
        end
        return ((d << amount) | (d >> (width - amount))) & mask;
    endfunction

    function automatic logic [63:0] sat_inc(
        input logic [63:0] value,
        input int unsigned width,
        input logic        inc
    );
        logic [63:0] max_val;
        max_val = (width >= c_max_bits) ? '1 : ((64'd1 << width) - 64'd1);
        if (inc && (value < max_val)) begin
            return value + 64'd1;
        end
        return value;
    endfunction

endpackage

`default_nettype wire

// File: rtl/elixirchip_es1_spu_delay.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_delay
//  Brief    : cke-gated shift register of DEPTH stages; DEPTH=0 is a wire.
//  Revision : 1.0
// ============================================================================

module elixirchip_es1_spu_delay
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int  DEPTH  = 1,
    parameter type data_t = logic,
    parameter data_t INIT = '0
) (
    input  logic  reset,
    input  logic  clk,
    input  logic  cke,
    input  data_t s_data,
    output data_t m_data
);

    generate
        if (DEPTH == 0) begin : g_pass
            logic w_unused;
            assign w_unused = ^{reset, clk, cke};
            assign m_data   = s_data;
        end else begin : g_pipe
            data_t r_stage [DEPTH];

            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= INIT;
                    end
                end else if (cke) begin
                    r_stage[0] <= s_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign m_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/elixirchip_es1_spu_op_xor_acc.sv
`default_nettype none
// ============================================================================
//  Module   : elixirchip_es1_spu_op_xor_acc
//  Brief    : Rotate-XOR checksum accumulator with saturating word counter.
//  Revision : 1.0
// ============================================================================

module elixirchip_es1_spu_op_xor_acc
    import elixirchip_es1_spu_pkg::*;
#(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter int    ROTATE     = 0,
    parameter data_t CLEAR_DATA = '0,
    parameter int    COUNT_BITS = 16,
    parameter string DEVICE     = "RTL",
    parameter string SIMULATION = "false",
    parameter string DEBUG      = "false"
) (
    input  logic                  reset,
    input  logic                  clk,
    input  logic                  cke,
    input  data_t                 s_data,
    input  logic                  s_clear,
    input  logic                  s_valid,
    output data_t                 m_data,
    output logic [COUNT_BITS-1:0] m_count,
    output logic                  m_valid
);

    generate
        if (LATENCY < 1 || ROTATE < 0 || ROTATE >= DATA_BITS
                || DATA_BITS > int'(c_max_bits) || COUNT_BITS < 1
                || COUNT_BITS > int'(c_max_bits)) begin : g_param_check
            $error("elixirchip_es1_spu_op_xor_acc: illegal LATENCY/ROTATE/width parameters");
        end
        if (DEVICE == "" || (SIMULATION != "true" && SIMULATION != "false")
                || (DEBUG != "true" && DEBUG != "false")) begin : g_flag_check
            $error("elixirchip_es1_spu_op_xor_acc: illegal DEVICE/SIMULATION/DEBUG value");
        end
    endgenerate

    data_t                 r_acc;
    logic [COUNT_BITS-1:0] r_cnt;
    logic                  r_valid;

    data_t                 w_base;
    data_t                 w_fold;
    data_t                 w_acc_next;
    logic [COUNT_BITS-1:0] w_cnt_base;
    logic [COUNT_BITS-1:0] w_cnt_next;

    // Clear takes effect before the fold, so clear+valid starts a fresh checksum.
    assign w_base     = s_clear ? CLEAR_DATA : r_acc;
    assign w_fold     = data_t'(rotl(64'(w_base), DATA_BITS, ROTATE)) ^ s_data;
    assign w_acc_next = s_valid ? w_fold : w_base;
    assign w_cnt_base = s_clear ? '0 : r_cnt;
    assign w_cnt_next = COUNT_BITS'(sat_inc(64'(w_cnt_base), COUNT_BITS, s_valid));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc   <= CLEAR_DATA;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else if (cke) begin
            r_acc   <= w_acc_next;
            r_cnt   <= w_cnt_next;
            r_valid <= s_valid;
        end
    end

    elixirchip_es1_spu_delay #(
        .DEPTH  (LATENCY - 1),
        .data_t (data_t),
        .INIT   (CLEAR_DATA)
    ) u_delay_data (
        .reset  (reset),
        .clk    (clk),
        .cke    (cke),
        .s_data (r_acc),
        .m_data (m_data)
    );

    elixirchip_es1_spu_delay #(
        .DEPTH  (LATENCY - 1),
        .data_t (logic [COUNT_BITS-1:0]),
        .INIT   ('0)
    ) u_delay_count (
        .reset  (reset),
        .clk    (clk),
        .cke    (cke),
        .s_data (r_cnt),
        .m_data (m_count)
    );

    elixirchip_es1_spu_delay #(
        .DEPTH  (LATENCY - 1),
        .data_t (logic),
        .INIT   (1'b0)
    ) u_delay_valid (
        .reset  (reset),
        .clk    (clk),
        .cke    (cke),
        .s_data (r_valid),
        .m_data (m_valid)
    );

endmodule

`default_nettype wire
